ysyx_22040125_idu_stage: RTL and testbench

//  Registered, parametrised RV decode stage with a FIFO buffer and valid/ready handshakes on both sides.
//  It sits between IFU and EXU and supports RV32/RV64, an optional M extension and illegal-instruction detection.

---
 rtl/ysyx_22040125_idu_stage.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_ysyx_22040125_idu_stage.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040125_idu_stage.sv
// Registered RV32/RV64 decode stage. Each accepted instruction is decoded
// combinationally and the decoded record is stored in a DEPTH-entry FIFO.
// The outputs always show the FIFO head.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid && ready && !flush.
//   in_ready depends only on the current occupancy (count < DEPTH).
//   out_valid depends only on the current occupancy (count != 0).
//   Neither ready nor valid looks at the other side in the same cycle, so
//   there is no combinational path from the input side to the output side.
//   flush drops every buffered entry and any same-cycle push or pop.
module ysyx_22040125_idu_stage #(
  parameter int XLEN  = 64,
  parameter bit EN_M  = 1'b1,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [14:0]     out_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_reg_wen,
  output logic            out_mem_ren,
  output logic            out_mem_wen,
  output logic [1:0]      out_mem_size,
  output logic            out_mem_uns,
  output logic [5:0]      out_br,
  output logic            out_w,
  output logic            out_ebreak,
  output logic            out_illegal
);

  localparam bit RV64 = (XLEN == 64);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);
  localparam logic [31:0] EBREAK = 32'h00100073;

  localparam logic [14:0] OP_ADD  = 15'h0001;
  localparam logic [14:0] OP_SUB  = 15'h0002;
  localparam logic [14:0] OP_SLL  = 15'h0004;
  localparam logic [14:0] OP_SLT  = 15'h0008;
  localparam logic [14:0] OP_SLTU = 15'h0010;
  localparam logic [14:0] OP_XOR  = 15'h0020;
  localparam logic [14:0] OP_SRL  = 15'h0040;
  localparam logic [14:0] OP_SRA  = 15'h0080;
  localparam logic [14:0] OP_OR   = 15'h0100;
  localparam logic [14:0] OP_AND  = 15'h0200;
  localparam logic [14:0] OP_LUI  = 15'h0400;
  localparam logic [14:0] OP_JAL  = 15'h0800;
  localparam logic [14:0] OP_MUL  = 15'h1000;
  localparam logic [14:0] OP_DIV  = 15'h2000;
  localparam logic [14:0] OP_REM  = 15'h4000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [14:0]     op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_wen;
    logic            mem_ren;
    logic            mem_wen;
    logic [1:0]      mem_size;
    logic            mem_uns;
    logic [5:0]      br;
    logic            w;
    logic            ebreak;
    logic            illegal;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            shamt_ok;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  entry_t          dec;
  logic            legal;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  // On RV32 the shift amount is only 5 bits, so inst[25] must stay clear.
  assign shamt_ok = RV64 || !in_inst[25];

  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

  // Decode the offered instruction into a FIFO record; illegal encodings keep pc/fields only.
  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    dec.pc  = in_pc;
    dec.rs1 = in_inst[19:15];
    dec.rs2 = in_inst[24:20];
    dec.rd  = in_inst[11:7];
    case (opcode)
      7'b0110111: begin
        legal = 1'b1; dec.op = OP_LUI; dec.imm = imm_u; dec.reg_wen = 1'b1;
      end
      7'b0010111: begin
        legal = 1'b1; dec.op = OP_ADD; dec.imm = imm_u; dec.reg_wen = 1'b1;
      end
      7'b1101111: begin
        legal = 1'b1; dec.op = OP_JAL; dec.imm = imm_j; dec.reg_wen = 1'b1;
      end
      7'b1100111: begin
        legal = (funct3 == 3'b000); dec.op = OP_JAL; dec.imm = imm_i; dec.reg_wen = 1'b1;
      end
      7'b1100011: begin
        legal = 1'b1; dec.op = OP_ADD; dec.imm = imm_b;
        case (funct3)
          3'b000:  dec.br = 6'b100000;
          3'b001:  dec.br = 6'b010000;
          3'b100:  dec.br = 6'b001000;
          3'b101:  dec.br = 6'b000100;
          3'b110:  dec.br = 6'b000010;
          3'b111:  dec.br = 6'b000001;
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        legal = (funct3 != 3'b111) && (RV64 || (funct3 != 3'b011 && funct3 != 3'b110));
        dec.op = OP_ADD; dec.imm = imm_i; dec.reg_wen = 1'b1; dec.mem_ren = 1'b1;
        dec.mem_size = funct3[1:0]; dec.mem_uns = funct3[2];
      end
      7'b0100011: begin
        legal = !funct3[2] && (RV64 || funct3[1:0] != 2'b11);
        dec.op = OP_ADD; dec.imm = imm_s; dec.mem_wen = 1'b1; dec.mem_size = funct3[1:0];
      end
      7'b0010011: begin
        legal = 1'b1; dec.imm = imm_i; dec.reg_wen = 1'b1;
        case (funct3)
          3'b000: dec.op = OP_ADD;
          3'b010: dec.op = OP_SLT;
          3'b011: dec.op = OP_SLTU;
          3'b100: dec.op = OP_XOR;
          3'b110: dec.op = OP_OR;
          3'b111: dec.op = OP_AND;
          3'b001: begin
            dec.op = OP_SLL;
            legal  = shamt_ok && (in_inst[31:26] == 6'b000000);
          end
          default: begin
            dec.op = in_inst[30] ? OP_SRA : OP_SRL;
            legal  = shamt_ok && (in_inst[31:26] == 6'b000000 || in_inst[31:26] == 6'b010000);
          end
        endcase
      end
      7'b0011011: begin
        dec.imm = imm_i; dec.reg_wen = 1'b1; dec.w = 1'b1;
        case (funct3)
          3'b000:  begin legal = 1'b1; dec.op = OP_ADD; end
          3'b001:  begin legal = (funct7 == 7'b0000000); dec.op = OP_SLL; end
          3'b101:  begin
            legal  = (funct7 == 7'b0000000 || funct7 == 7'b0100000);
            dec.op = in_inst[30] ? OP_SRA : OP_SRL;
          end
          default: legal = 1'b0;
        endcase
        legal = legal && RV64;
      end
      7'b0110011: begin
        dec.reg_wen = 1'b1;
        case (funct7)
          7'b0000000: begin
            legal = 1'b1;
            case (funct3)
              3'b000:  dec.op = OP_ADD;
              3'b001:  dec.op = OP_SLL;
              3'b010:  dec.op = OP_SLT;
              3'b011:  dec.op = OP_SLTU;
              3'b100:  dec.op = OP_XOR;
              3'b101:  dec.op = OP_SRL;
              3'b110:  dec.op = OP_OR;
              default: dec.op = OP_AND;
            endcase
          end
          7'b0100000: begin
            legal  = (funct3 == 3'b000 || funct3 == 3'b101);
            dec.op = (funct3 == 3'b000) ? OP_SUB : OP_SRA;
          end
          7'b0000001: begin
            legal  = EN_M;
            dec.op = !funct3[2] ? OP_MUL : (funct3[1] ? OP_REM : OP_DIV);
          end
          default: legal = 1'b0;
        endcase
      end
      7'b0111011: begin
        dec.reg_wen = 1'b1; dec.w = 1'b1;
        case (funct7)
          7'b0000000: begin
            legal  = (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101);
            dec.op = (funct3 == 3'b000) ? OP_ADD : ((funct3 == 3'b001) ? OP_SLL : OP_SRL);
          end
          7'b0100000: begin
            legal  = (funct3 == 3'b000 || funct3 == 3'b101);
            dec.op = (funct3 == 3'b000) ? OP_SUB : OP_SRA;
          end
          7'b0000001: begin
            // Only mulw/divw/divuw/remw/remuw exist in the 32-bit form.
            legal  = EN_M && (funct3 == 3'b000 || funct3[2]);
            dec.op = !funct3[2] ? OP_MUL : (funct3[1] ? OP_REM : OP_DIV);
          end
          default: legal = 1'b0;
        endcase
        legal = legal && RV64;
      end
      default: begin
        if (in_inst == EBREAK) begin
          legal = 1'b1; dec.ebreak = 1'b1; dec.rs1 = 5'd10;
        end
      end
    endcase
    if (!legal) begin
      dec.op       = '0;
      dec.reg_wen  = 1'b0;
      dec.mem_ren  = 1'b0;
      dec.mem_wen  = 1'b0;
      dec.mem_size = 2'b00;
      dec.mem_uns  = 1'b0;
      dec.br       = '0;
      dec.w        = 1'b0;
      dec.illegal  = 1'b1;
    end
  end

  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready  = (cnt_q < DEPTH_C);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Next pointer/occupancy: flush zeroes everything, otherwise pointers wrap at DEPTH.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = (wr_q == LAST_P) ? '0 : wr_q + 1'b1;
      if (pop)  rd_d = (rd_q == LAST_P) ? '0 : rd_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO state; reset also clears entries so the idle head reads as all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      if (push) fifo_q[wr_q] <= dec;
    end
  end

  entry_t head;
  assign head = fifo_q[rd_q];

  assign out_pc       = head.pc;
  assign out_imm      = head.imm;
  assign out_op       = head.op;
  assign out_rs1      = head.rs1;
  assign out_rs2      = head.rs2;
  assign out_rd       = head.rd;
  assign out_reg_wen  = head.reg_wen;
  assign out_mem_ren  = head.mem_ren;
  assign out_mem_wen  = head.mem_wen;
  assign out_mem_size = head.mem_size;
  assign out_mem_uns  = head.mem_uns;
  assign out_br       = head.br;
  assign out_w        = head.w;
  assign out_ebreak   = head.ebreak;
  assign out_illegal  = head.illegal;

endmodule

// File: tb/tb_ysyx_22040125_idu_stage.sv
// Bench for the decode stage: two instances (RV64 with M, depth 2; RV32
// without M, depth 3) share one stimulus stream. A reference decoder and
// per-instance expected queues predict every head record.
module tb_ysyx_22040125_idu_stage;

  localparam int A_DEPTH = 2;
  localparam int B_DEPTH = 3;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [14:0] op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_wen;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  mem_size;
    logic        mem_uns;
    logic [5:0]  br;
    logic        w;
    logic        ebreak;
    logic        illegal;
  } rec_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid, a_out_reg_wen, a_out_mem_ren, a_out_mem_wen;
  logic        a_out_mem_uns, a_out_w, a_out_ebreak, a_out_illegal;
  logic [63:0] a_out_pc, a_out_imm;
  logic [14:0] a_out_op;
  logic [4:0]  a_out_rs1, a_out_rs2, a_out_rd;
  logic [1:0]  a_out_mem_size;
  logic [5:0]  a_out_br;

  logic        b_in_ready, b_out_valid, b_out_reg_wen, b_out_mem_ren, b_out_mem_wen;
  logic        b_out_mem_uns, b_out_w, b_out_ebreak, b_out_illegal;
  logic [31:0] b_out_pc, b_out_imm;
  logic [14:0] b_out_op;
  logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
  logic [1:0]  b_out_mem_size;
  logic [5:0]  b_out_br;

  ysyx_22040125_idu_stage #(.XLEN(64), .EN_M(1'b1), .DEPTH(A_DEPTH)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_imm(a_out_imm), .out_op(a_out_op), .out_rs1(a_out_rs1),
    .out_rs2(a_out_rs2), .out_rd(a_out_rd), .out_reg_wen(a_out_reg_wen),
    .out_mem_ren(a_out_mem_ren), .out_mem_wen(a_out_mem_wen), .out_mem_size(a_out_mem_size),
    .out_mem_uns(a_out_mem_uns), .out_br(a_out_br), .out_w(a_out_w),
    .out_ebreak(a_out_ebreak), .out_illegal(a_out_illegal)
  );

  ysyx_22040125_idu_stage #(.XLEN(32), .EN_M(1'b0), .DEPTH(B_DEPTH)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_imm(b_out_imm), .out_op(b_out_op), .out_rs1(b_out_rs1),
    .out_rs2(b_out_rs2), .out_rd(b_out_rd), .out_reg_wen(b_out_reg_wen),
    .out_mem_ren(b_out_mem_ren), .out_mem_wen(b_out_mem_wen), .out_mem_size(b_out_mem_size),
    .out_mem_uns(b_out_mem_uns), .out_br(b_out_br), .out_w(b_out_w),
    .out_ebreak(b_out_ebreak), .out_illegal(b_out_illegal)
  );

  // ---------------- scoreboard ----------------
  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t exp_q_a[$];
  rec_t exp_q_b[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decoder: instruction semantics by mnemonic class, sized to 64 bits.
  function automatic rec_t ref_decode(input logic [31:0] i, input logic [63:0] pc,
                                      input int xlen, input bit en_m);
    rec_t        r;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [5:0]  top6;
    logic [63:0] imm;
    bit          ok;
    int          opi;
    opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25]; top6 = i[31:26];
    r = '0; ok = 0; opi = -1; imm = 64'd0;
    r.pc  = (xlen == 32) ? {32'd0, pc[31:0]} : pc;
    r.rs1 = i[19:15]; r.rs2 = i[24:20]; r.rd = i[11:7];
    case (opc)
      7'h37: begin ok = 1; opi = 10; imm = 64'($signed({i[31:12], 12'b0})); r.reg_wen = 1; end
      7'h17: begin ok = 1; opi = 0;  imm = 64'($signed({i[31:12], 12'b0})); r.reg_wen = 1; end
      7'h6f: begin
        ok = 1; opi = 11; r.reg_wen = 1;
        imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      7'h67: begin ok = (f3 == 0); opi = 11; imm = 64'($signed(i[31:20])); r.reg_wen = 1; end
      7'h63: begin
        ok = 1; opi = 0; imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        case (f3)
          0: r.br[5] = 1;  1: r.br[4] = 1;  4: r.br[3] = 1;
          5: r.br[2] = 1;  6: r.br[1] = 1;  7: r.br[0] = 1;
          default: ok = 0;
        endcase
      end
      7'h03: begin
        ok = (f3 != 7) && !(xlen == 32 && (f3 == 3 || f3 == 6));
        opi = 0; imm = 64'($signed(i[31:20])); r.reg_wen = 1; r.mem_ren = 1;
        r.mem_size = f3[1:0]; r.mem_uns = (f3 >= 4);
      end
      7'h23: begin
        ok = (f3 <= 2) || (f3 == 3 && xlen == 64);
        opi = 0; imm = 64'($signed({i[31:25], i[11:7]})); r.mem_wen = 1; r.mem_size = f3[1:0];
      end
      7'h13: begin
        imm = 64'($signed(i[31:20])); r.reg_wen = 1; ok = 1;
        case (f3)
          0: opi = 0;  2: opi = 3;  3: opi = 4;  4: opi = 5;  6: opi = 8;  7: opi = 9;
          1: begin opi = 2; ok = (top6 == 0) && (xlen == 64 || i[25] == 0); end
          default: begin
            ok  = (top6 == 0 || top6 == 6'b010000) && (xlen == 64 || i[25] == 0);
            opi = (top6 == 0) ? 6 : 7;
          end
        endcase
      end
      7'h1b: begin
        imm = 64'($signed(i[31:20])); r.reg_wen = 1; r.w = 1;
        if (f3 == 0) begin ok = 1; opi = 0; end
        else if (f3 == 1) begin ok = (f7 == 0); opi = 2; end
        else if (f3 == 5) begin ok = (f7 == 0 || f7 == 7'h20); opi = (f7 == 0) ? 6 : 7; end
        ok = ok && (xlen == 64);
      end
      7'h33: begin
        r.reg_wen = 1;
        if (f7 == 0) begin
          ok = 1;
          case (f3) 0: opi = 0; 1: opi = 2; 2: opi = 3; 3: opi = 4;
                    4: opi = 5; 5: opi = 6; 6: opi = 8; default: opi = 9; endcase
        end else if (f7 == 7'h20) begin
          ok = (f3 == 0 || f3 == 5); opi = (f3 == 0) ? 1 : 7;
        end else if (f7 == 7'h01) begin
          ok = en_m; opi = (f3 < 4) ? 12 : ((f3 < 6) ? 13 : 14);
        end
      end
      7'h3b: begin
        r.reg_wen = 1; r.w = 1;
        if (f7 == 0) begin
          ok = (f3 == 0 || f3 == 1 || f3 == 5); opi = (f3 == 0) ? 0 : ((f3 == 1) ? 2 : 6);
        end else if (f7 == 7'h20) begin
          ok = (f3 == 0 || f3 == 5); opi = (f3 == 0) ? 1 : 7;
        end else if (f7 == 7'h01) begin
          ok = en_m && (f3 == 0 || f3 >= 4); opi = (f3 < 4) ? 12 : ((f3 < 6) ? 13 : 14);
        end
        ok = ok && (xlen == 64);
      end
      default: begin
        if (i == 32'h00100073) begin ok = 1; r.ebreak = 1; r.rs1 = 5'd10; end
      end
    endcase
    r.imm = (xlen == 32) ? {32'd0, imm[31:0]} : imm;
    if (ok && opi >= 0) r.op = 15'(1) << opi;
    if (!ok) begin
      r.op = '0; r.reg_wen = 0; r.mem_ren = 0; r.mem_wen = 0; r.w = 0; r.br = '0;
      r.illegal = 1;
    end
    return r;
  endfunction

  function automatic rec_t obs_a();
    rec_t o;
    o.pc = a_out_pc; o.imm = a_out_imm; o.op = a_out_op;
    o.rs1 = a_out_rs1; o.rs2 = a_out_rs2; o.rd = a_out_rd;
    o.reg_wen = a_out_reg_wen; o.mem_ren = a_out_mem_ren; o.mem_wen = a_out_mem_wen;
    o.mem_size = a_out_mem_size; o.mem_uns = a_out_mem_uns; o.br = a_out_br;
    o.w = a_out_w; o.ebreak = a_out_ebreak; o.illegal = a_out_illegal;
    return o;
  endfunction

  function automatic rec_t obs_b();
    rec_t o;
    o.pc = {32'd0, b_out_pc}; o.imm = {32'd0, b_out_imm}; o.op = b_out_op;
    o.rs1 = b_out_rs1; o.rs2 = b_out_rs2; o.rd = b_out_rd;
    o.reg_wen = b_out_reg_wen; o.mem_ren = b_out_mem_ren; o.mem_wen = b_out_mem_wen;
    o.mem_size = b_out_mem_size; o.mem_uns = b_out_mem_uns; o.br = b_out_br;
    o.w = b_out_w; o.ebreak = b_out_ebreak; o.illegal = b_out_illegal;
    return o;
  endfunction

  task automatic compare_rec(input string who, input rec_t got, input rec_t exp);
    check({who, "_pc"},      got.pc,      exp.pc);
    check({who, "_op"},      64'(got.op), 64'(exp.op));
    check({who, "_reg_wen"}, 64'(got.reg_wen), 64'(exp.reg_wen));
    check({who, "_mem_ren"}, 64'(got.mem_ren), 64'(exp.mem_ren));
    check({who, "_mem_wen"}, 64'(got.mem_wen), 64'(exp.mem_wen));
    check({who, "_br"},      64'(got.br),  64'(exp.br));
    check({who, "_w"},       64'(got.w),   64'(exp.w));
    check({who, "_ebreak"},  64'(got.ebreak),  64'(exp.ebreak));
    check({who, "_illegal"}, 64'(got.illegal), 64'(exp.illegal));
    if (!exp.illegal) begin
      check({who, "_imm"},      got.imm, exp.imm);
      check({who, "_rs1"},      64'(got.rs1), 64'(exp.rs1));
      check({who, "_rs2"},      64'(got.rs2), 64'(exp.rs2));
      check({who, "_rd"},       64'(got.rd),  64'(exp.rd));
      check({who, "_mem_size"}, 64'(got.mem_size), 64'(exp.mem_size));
      check({who, "_mem_uns"},  64'(got.mem_uns),  64'(exp.mem_uns));
    end
  endtask

  task automatic check_outputs();
    check("a_in_ready",  64'(a_in_ready),  64'(exp_q_a.size() < A_DEPTH));
    check("a_out_valid", 64'(a_out_valid), 64'(exp_q_a.size() != 0));
    if (exp_q_a.size() != 0) compare_rec("a", obs_a(), exp_q_a[0]);
    check("b_in_ready",  64'(b_in_ready),  64'(exp_q_b.size() < B_DEPTH));
    check("b_out_valid", 64'(b_out_valid), 64'(exp_q_b.size() != 0));
    if (exp_q_b.size() != 0) compare_rec("b", obs_b(), exp_q_b[0]);
  endtask

  // Advance the expected queues by what the coming edge does.
  task automatic model_update();
    bit push_a, push_b, pop_a, pop_b;
    if (rst || flush) begin
      exp_q_a.delete();
      exp_q_b.delete();
    end else begin
      push_a = in_valid && (exp_q_a.size() < A_DEPTH);
      pop_a  = out_ready && (exp_q_a.size() != 0);
      push_b = in_valid && (exp_q_b.size() < B_DEPTH);
      pop_b  = out_ready && (exp_q_b.size() != 0);
      if (pop_a)  void'(exp_q_a.pop_front());
      if (pop_b)  void'(exp_q_b.pop_front());
      if (push_a) exp_q_a.push_back(ref_decode(in_inst, in_pc, 64, 1'b1));
      if (push_b) exp_q_b.push_back(ref_decode(in_inst, in_pc, 32, 1'b0));
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive on the falling edge, check, predict, then return 1 unit after the rising edge.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] inst, input logic [63:0] pc);
    cycle(1'b1, inst, pc, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 13))
      0:  i[6:0] = 7'h37;
      1:  i[6:0] = 7'h17;
      2:  i[6:0] = 7'h6f;
      3:  i[6:0] = 7'h67;
      4:  i[6:0] = 7'h63;
      5:  i[6:0] = 7'h03;
      6:  i[6:0] = 7'h23;
      7:  i[6:0] = 7'h13;
      8:  i[6:0] = 7'h1b;
      9:  i[6:0] = 7'h33;
      10: i[6:0] = 7'h3b;
      11: return 32'h00100073;
      default: return i;
    endcase
    if ($urandom_range(0, 3) != 0) begin
      case ($urandom_range(0, 2))
        0:       i[31:25] = 7'b0000000;
        1:       i[31:25] = 7'b0100000;
        default: i[31:25] = 7'b0000001;
      endcase
    end
    return i;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'd0; in_pc = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    cycle(1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
    // Reset state: everything visible is zero.
    check("rst_a_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_ready", 64'(a_in_ready), 64'd1);
    check("rst_a_pc",    a_out_pc, 64'd0);
    check("rst_a_op",    64'(a_out_op), 64'd0);
    check("rst_a_illegal", 64'(a_out_illegal), 64'd0);
    check("rst_b_valid", 64'(b_out_valid), 64'd0);
    check("rst_b_imm",   64'(b_out_imm), 64'd0);
    rst = 1'b0;

    // addi x1,x0,5
    push1(32'h00500093, 64'h8000_0000);
    check("t1_valid", 64'(a_out_valid), 64'd1);
    check("t1_imm",   a_out_imm, 64'd5);
    check("t1_op",    64'(a_out_op), 64'h1);
    check("t1_rd",    64'(a_out_rd), 64'd1);
    check("t1_wen",   64'(a_out_reg_wen), 64'd1);
    check("t1_illegal", 64'(a_out_illegal), 64'd0);
    check("t1_pc",    a_out_pc, 64'h8000_0000);
    check("t1_b_imm", 64'(b_out_imm), 64'd5);

    // mul x3,x1,x2 with and without M
    push1(32'h022081b3, 64'h8000_0004);
    check("t4_a_op",      64'(a_out_op), 64'h1000);
    check("t4_a_wen",     64'(a_out_reg_wen), 64'd1);
    check("t4_a_illegal", 64'(a_out_illegal), 64'd0);
    check("t4_b_illegal", 64'(b_out_illegal), 64'd1);
    check("t4_b_op",      64'(b_out_op), 64'd0);
    check("t4_b_wen",     64'(b_out_reg_wen), 64'd0);

    // ld on RV64 vs RV32, then addiw
    push1(32'h0000b103, 64'h8000_0008);
    check("t5_a_ren",     64'(a_out_mem_ren), 64'd1);
    check("t5_a_size",    64'(a_out_mem_size), 64'd3);
    check("t5_b_illegal", 64'(b_out_illegal), 64'd1);
    push1(32'h0010809b, 64'h8000_000c);
    check("t5_a_w",       64'(a_out_w), 64'd1);
    check("t5_a_op",      64'(a_out_op), 64'h1);
    check("t5_b_illegal_w", 64'(b_out_illegal), 64'd1);

    // ebreak and an all-ones word
    push1(32'h00100073, 64'h8000_0010);
    check("t6_ebreak",  64'(a_out_ebreak), 64'd1);
    check("t6_rs1",     64'(a_out_rs1), 64'd10);
    check("t6_legal",   64'(a_out_illegal), 64'd0);
    check("t6_b_ebreak", 64'(b_out_ebreak), 64'd1);
    push1(32'hffffffff, 64'h8000_0014);
    check("t6_ones_a", 64'(a_out_illegal), 64'd1);
    check("t6_ones_b", 64'(b_out_illegal), 64'd1);
    cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

    // Backpressure on the depth-2 instance, then in-order drain.
    cycle(1'b1, 32'h00100093, 64'h100, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200093, 64'h104, 1'b0, 1'b0);
    check("t2_full",  64'(a_in_ready), 64'd0);
    check("t2_head1", a_out_pc, 64'h100);
    cycle(1'b1, 32'h00300093, 64'h108, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300093, 64'h108, 1'b1, 1'b0);
    check("t2_head2", a_out_pc, 64'h104);
    check("t2_ready", 64'(a_in_ready), 64'd1);
    cycle(1'b1, 32'h00300093, 64'h108, 1'b1, 1'b0);
    check("t2_head3", a_out_pc, 64'h108);
    check("t2_valid", 64'(a_out_valid), 64'd1);

    // Flush with two entries buffered and a simultaneous push.
    cycle(1'b1, 32'h00400093, 64'h10c, 1'b0, 1'b0);
    check("t3_full", 64'(a_in_ready), 64'd0);
    cycle(1'b1, 32'h00500093, 64'h110, 1'b1, 1'b1);
    check("t3_a_valid", 64'(a_out_valid), 64'd0);
    check("t3_a_ready", 64'(a_in_ready), 64'd1);
    check("t3_b_valid", 64'(b_out_valid), 64'd0);

    // Reset mid-stream beats flush and handshakes, and clears entries.
    cycle(1'b1, 32'h00600093, 64'h114, 1'b0, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 32'h00700093, 64'h118, 1'b1, 1'b1);
    rst = 1'b0;
    check("rst2_a_valid", 64'(a_out_valid), 64'd0);
    check("rst2_a_pc",    a_out_pc, 64'd0);
    check("rst2_a_imm",   a_out_imm, 64'd0);
    check("rst2_b_op",    64'(b_out_op), 64'd0);

    // Random traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      cycle($urandom_range(0, 3) != 0, gen_inst(), {$urandom, $urandom},
            $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
    end
    rst = 1'b0;
    repeat (4) cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
